mem_port_arbiter: RTL

- Shares the single-port instruction/data memory (DP_mem32x64k, 64k x 32) between the instruction-fetch port and the load/store data port.
- Per cycle, grants at most one requester the memory address and write strobe.
- Tracks the owner of each in-flight read so the 1-cycle-latency read data returns to the correct requester.
- Bounded-starvation priority: data wins conflicts by default; instruction fetch is forced through after STARVE_LIM consecutive denials.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_starve_cnt.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// The read-owner encoding matches the values the memory-side trace tools expect.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_WORD_W = 32;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } rd_owner_e;

    // Owner of the read issued this cycle; writes and idle cycles leave no read in flight.
    function automatic rd_owner_e next_owner(input logic i_gnt, input logic d_gnt, input logic d_we);
        rd_owner_e own;
        own = OWN_NONE;
        if (i_gnt) begin
            own = OWN_INST;
        end else if (d_gnt && !d_we) begin
            own = OWN_DATA;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive cycles a pending fetch has been denied.
// ge_lim tells the grant logic to let the fetch through on the next conflict.
module mem_port_arbiter_starve_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic ge_lim
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < LIM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        ge_lim = (cnt_q >= LIM);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port 64k x 32 memory between instruction fetch and load/store.
// Data wins conflicts unless fetch has been denied STARVE_LIM cycles in a row.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [WORD_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [WORD_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [WORD_W-1:0] d_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [WORD_W-1:0] mem_wdata_o,
    input  logic [WORD_W-1:0] mem_rdata_i
);

    logic      starve_ge_lim;
    logic      starve_inc;
    logic      starve_clr;
    logic      i_win;
    logic      d_win;
    logic      i_gnt;
    logic      d_gnt;
    rd_owner_e rd_owner_q;
    rd_owner_e rd_owner_d;

    mem_port_arbiter_starve_cnt #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .ge_lim (starve_ge_lim)
    );

    // Grants are held off while reset is asserted so nothing reaches the memory.
    always_comb begin
        i_win = i_req_i & (~d_req_i | starve_ge_lim);
        d_win = d_req_i & ~i_win;
        i_gnt = i_win & ~rst;
        d_gnt = d_win & ~rst;
    end

    always_comb begin
        starve_inc = i_req_i & ~i_gnt;
        starve_clr = i_gnt | ~i_req_i;
    end

    // Idle cycles still present the fetch address so the memory can stream ahead.
    always_comb begin
        mem_addr_o  = d_gnt ? d_addr_i : i_addr_i;
        mem_we_o    = d_gnt & d_we_i;
        mem_wdata_o = d_wdata_i;
    end

    always_comb begin
        rd_owner_d = next_owner(i_gnt, d_gnt, d_we_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        i_gnt_o    = i_gnt;
        d_gnt_o    = d_gnt;
        i_rvalid_o = (rd_owner_q == OWN_INST);
        d_rvalid_o = (rd_owner_q == OWN_DATA);
        i_rdata_o  = mem_rdata_i;
        d_rdata_o  = mem_rdata_i;
    end

endmodule
